// File: rtl/hazard_fwd_unit_pkg.sv
// Forwarding-mux select codes shared by hazard_fwd_unit and the datapath muxes.
package hazard_fwd_unit_pkg;

  // EX-stage operand mux (A, B, store data C) and MEM-stage store-data mux
  localparam logic [2:0] FORWARD_IDEX  = 3'd0;
  localparam logic [2:0] FORWARD_EXMEM = 3'd1;
  localparam logic [2:0] FORWARD_MEMWB = 3'd2;

  // ID-stage branch / jr operand mux
  localparam logic [2:0] FORWARD_RF              = 3'd0;
  localparam logic [2:0] FORWARD_EXMEM_ALURESULT = 3'd1;
  localparam logic [2:0] FORWARD_EXMEM_PCPLUS4   = 3'd2;

  localparam int SLOT_FIXED_BITS = 7;

endpackage

// File: rtl/hazard_shadow_slot.sv
// One shadow pipeline slot: captures the incoming instruction tags on load_i,
// otherwise becomes a fully cleared bubble.
module hazard_shadow_slot
  import hazard_fwd_unit_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_i,
  input  logic          valid_i,
  input  logic [AW-1:0] dst_i,
  input  logic          reg_write_i,
  input  logic          mem_read_i,
  input  logic          link_i,
  input  logic [AW-1:0] srca_i,
  input  logic          srca_used_i,
  input  logic [AW-1:0] srcb_i,
  input  logic          srcb_used_i,
  input  logic [AW-1:0] st_rt_i,
  input  logic          mem_write_i,
  output logic          valid_o,
  output logic [AW-1:0] dst_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          link_o,
  output logic [AW-1:0] srca_o,
  output logic          srca_used_o,
  output logic [AW-1:0] srcb_o,
  output logic          srcb_used_o,
  output logic [AW-1:0] st_rt_o,
  output logic          mem_write_o
);

  localparam int W = 4 * AW + SLOT_FIXED_BITS;

  logic [W-1:0] slot_d;
  logic [W-1:0] slot_q;

  // Next slot contents: captured instruction or an all-zero bubble
  always_comb begin
    slot_d = {W{1'b0}};
    if (load_i) begin
      slot_d = {valid_i, dst_i, reg_write_i, mem_read_i, link_i,
                srca_i, srca_used_i, srcb_i, srcb_used_i, st_rt_i, mem_write_i};
    end else begin
      slot_d = {W{1'b0}};
    end
  end

  // Slot register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q <= {W{1'b0}};
    end else begin
      slot_q <= slot_d;
    end
  end

  assign {valid_o, dst_o, reg_write_o, mem_read_o, link_o,
          srca_o, srca_used_o, srcb_o, srcb_used_o, st_rt_o, mem_write_o} = slot_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding-select and stall generator for the 5-stage MIPS core.
// Define HAZARD_STATS_EN to add the stall/load-use/branch-stall cycle counters.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_srca_rt,
  input  logic              id_srcb_reg,
  input  logic              id_mem_write,
  input  logic              id_is_branch,
  input  logic              id_is_jr,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_link,
  output logic [2:0]        ex_fwd_a,
  output logic [2:0]        ex_fwd_b,
  output logic [2:0]        ex_fwd_c,
  output logic [2:0]        mem_fwd,
  output logic [2:0]        id_fwd_jr,
  output logic [2:0]        id_fwd_br_a,
  output logic [2:0]        id_fwd_br_b,
  output logic              stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_load_use,
  output logic [31:0]       stat_branch_stall
`endif
);

  function automatic logic writes_reg(input logic v, input logic rw,
                                      input logic [REG_AW-1:0] dst,
                                      input logic [REG_AW-1:0] r);
    return v & rw & (dst == r) & (r != {REG_AW{1'b0}});
  endfunction

  function automatic logic [2:0] ex_select(input logic used, input logic hit_mem,
                                           input logic hit_wb);
    logic [2:0] code;
    if (used && hit_mem) begin
      code = FORWARD_EXMEM;
    end else if (used && hit_wb) begin
      code = FORWARD_MEMWB;
    end else begin
      code = FORWARD_IDEX;
    end
    return code;
  endfunction

  logic              ex_valid_s, ex_rw_s, ex_mr_s, ex_link_s, ex_srca_used_s, ex_srcb_used_s, ex_mw_s;
  logic [REG_AW-1:0] ex_dst_s, ex_srca_s, ex_srcb_s, ex_st_rt_s;
  logic              mem_valid_s, mem_rw_s, mem_mr_s, mem_link_s, mem_srca_used_s, mem_srcb_used_s, mem_mw_s;
  logic [REG_AW-1:0] mem_dst_s, mem_srca_s, mem_srcb_s, mem_st_rt_s;
  logic              wb_valid_s, wb_rw_s, wb_mr_s, wb_link_s, wb_srca_used_s, wb_srcb_used_s, wb_mw_s;
  logic [REG_AW-1:0] wb_dst_s, wb_srca_s, wb_srcb_s, wb_st_rt_s;

  logic              ex_load_s;
  logic [REG_AW-1:0] id_srca_s;
  logic              id_srca_used_s;

  // Operand A reads rt for shift-style instructions, rs otherwise
  assign id_srca_s      = id_srca_rt ? id_rt : id_rs;
  assign id_srca_used_s = id_srca_rt ? 1'b1  : id_use_rs;
  assign ex_load_s      = id_valid & ~stall;

  hazard_shadow_slot #(.AW(REG_AW)) u_ex_slot (
    .clk(clk), .rstn(rstn), .load_i(ex_load_s), .valid_i(1'b1),
    .dst_i(id_dst), .reg_write_i(id_reg_write), .mem_read_i(id_mem_read), .link_i(id_link),
    .srca_i(id_srca_s), .srca_used_i(id_srca_used_s), .srcb_i(id_rt), .srcb_used_i(id_srcb_reg),
    .st_rt_i(id_rt), .mem_write_i(id_mem_write),
    .valid_o(ex_valid_s), .dst_o(ex_dst_s), .reg_write_o(ex_rw_s), .mem_read_o(ex_mr_s),
    .link_o(ex_link_s), .srca_o(ex_srca_s), .srca_used_o(ex_srca_used_s), .srcb_o(ex_srcb_s),
    .srcb_used_o(ex_srcb_used_s), .st_rt_o(ex_st_rt_s), .mem_write_o(ex_mw_s)
  );

  hazard_shadow_slot #(.AW(REG_AW)) u_mem_slot (
    .clk(clk), .rstn(rstn), .load_i(ex_valid_s), .valid_i(1'b1),
    .dst_i(ex_dst_s), .reg_write_i(ex_rw_s), .mem_read_i(ex_mr_s), .link_i(ex_link_s),
    .srca_i(ex_srca_s), .srca_used_i(ex_srca_used_s), .srcb_i(ex_srcb_s), .srcb_used_i(ex_srcb_used_s),
    .st_rt_i(ex_st_rt_s), .mem_write_i(ex_mw_s),
    .valid_o(mem_valid_s), .dst_o(mem_dst_s), .reg_write_o(mem_rw_s), .mem_read_o(mem_mr_s),
    .link_o(mem_link_s), .srca_o(mem_srca_s), .srca_used_o(mem_srca_used_s), .srcb_o(mem_srcb_s),
    .srcb_used_o(mem_srcb_used_s), .st_rt_o(mem_st_rt_s), .mem_write_o(mem_mw_s)
  );

  hazard_shadow_slot #(.AW(REG_AW)) u_wb_slot (
    .clk(clk), .rstn(rstn), .load_i(mem_valid_s), .valid_i(1'b1),
    .dst_i(mem_dst_s), .reg_write_i(mem_rw_s), .mem_read_i(mem_mr_s), .link_i(mem_link_s),
    .srca_i(mem_srca_s), .srca_used_i(mem_srca_used_s), .srcb_i(mem_srcb_s), .srcb_used_i(mem_srcb_used_s),
    .st_rt_i(mem_st_rt_s), .mem_write_i(mem_mw_s),
    .valid_o(wb_valid_s), .dst_o(wb_dst_s), .reg_write_o(wb_rw_s), .mem_read_o(wb_mr_s),
    .link_o(wb_link_s), .srca_o(wb_srca_s), .srca_used_o(wb_srca_used_s), .srcb_o(wb_srcb_s),
    .srcb_used_o(wb_srcb_used_s), .st_rt_o(wb_st_rt_s), .mem_write_o(wb_mw_s)
  );

  // The WB slot only acts as a producer; its source tags are carried but never consumed
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_mr_s, wb_link_s, wb_srca_s, wb_srca_used_s, wb_srcb_s,
                         wb_srcb_used_s, wb_st_rt_s, wb_mw_s};

  // EX-stage operand and store-data selects; MEM producer beats WB
  always_comb begin
    ex_fwd_a = ex_select(ex_valid_s & ex_srca_used_s,
                         writes_reg(mem_valid_s, mem_rw_s, mem_dst_s, ex_srca_s),
                         writes_reg(wb_valid_s, wb_rw_s, wb_dst_s, ex_srca_s));
    ex_fwd_b = ex_select(ex_valid_s & ex_srcb_used_s,
                         writes_reg(mem_valid_s, mem_rw_s, mem_dst_s, ex_srcb_s),
                         writes_reg(wb_valid_s, wb_rw_s, wb_dst_s, ex_srcb_s));
    ex_fwd_c = ex_select(ex_valid_s & ex_mw_s,
                         writes_reg(mem_valid_s, mem_rw_s, mem_dst_s, ex_st_rt_s),
                         writes_reg(wb_valid_s, wb_rw_s, wb_dst_s, ex_st_rt_s));
  end

  // Store in MEM picks up data from a load/ALU op that has just reached WB
  always_comb begin
    mem_fwd = FORWARD_EXMEM;
    if (mem_valid_s && mem_mw_s && writes_reg(wb_valid_s, wb_rw_s, wb_dst_s, mem_st_rt_s)) begin
      mem_fwd = FORWARD_MEMWB;
    end else begin
      mem_fwd = FORWARD_EXMEM;
    end
  end

  logic mem_hit_rs_s, mem_hit_rt_s, ex_hit_rs_s, ex_hit_rt_s;
  logic mem_alu_s, br_rs_used_s, br_rt_used_s, alu_rt_used_s;

  assign mem_hit_rs_s  = writes_reg(mem_valid_s, mem_rw_s, mem_dst_s, id_rs);
  assign mem_hit_rt_s  = writes_reg(mem_valid_s, mem_rw_s, mem_dst_s, id_rt);
  assign ex_hit_rs_s   = writes_reg(ex_valid_s, ex_rw_s, ex_dst_s, id_rs);
  assign ex_hit_rt_s   = writes_reg(ex_valid_s, ex_rw_s, ex_dst_s, id_rt);
  assign mem_alu_s     = ~mem_mr_s & ~mem_link_s;
  assign br_rs_used_s  = id_is_jr | (id_is_branch & id_use_rs);
  assign br_rt_used_s  = id_is_branch & id_use_rt;
  assign alu_rt_used_s = id_srcb_reg | id_srca_rt;

  // ID-stage branch and jr operand selects
  always_comb begin
    id_fwd_br_a = FORWARD_RF;
    id_fwd_br_b = FORWARD_RF;
    id_fwd_jr   = FORWARD_RF;
    if (id_valid && id_is_branch && id_use_rs && mem_hit_rs_s && mem_alu_s) begin
      id_fwd_br_a = FORWARD_EXMEM_ALURESULT;
    end else begin
      id_fwd_br_a = FORWARD_RF;
    end
    if (id_valid && id_is_branch && id_use_rt && mem_hit_rt_s && mem_alu_s) begin
      id_fwd_br_b = FORWARD_EXMEM_ALURESULT;
    end else begin
      id_fwd_br_b = FORWARD_RF;
    end
    if (id_valid && id_is_jr && mem_hit_rs_s && mem_link_s) begin
      id_fwd_jr = FORWARD_EXMEM_PCPLUS4;
    end else if (id_valid && id_is_jr && mem_hit_rs_s && mem_alu_s) begin
      id_fwd_jr = FORWARD_EXMEM_ALURESULT;
    end else begin
      id_fwd_jr = FORWARD_RF;
    end
  end

  logic ex_src_hit_s, load_use_s, link_use_s, br_ex_s, br_mem_s, br_stall_s;

  assign ex_src_hit_s = (ex_hit_rs_s & id_use_rs) | (ex_hit_rt_s & alu_rt_used_s);
  assign load_use_s   = id_valid & ex_mr_s & ex_src_hit_s;
  assign link_use_s   = id_valid & ex_link_s & ex_src_hit_s;
  assign br_ex_s      = id_valid & ((ex_hit_rs_s & br_rs_used_s) | (ex_hit_rt_s & br_rt_used_s));
  // A load in MEM is not yet resolvable in ID; a link in MEM is only forwardable to jr
  assign br_mem_s     = id_valid & (mem_mr_s | (mem_link_s & id_is_branch)) &
                        ((mem_hit_rs_s & br_rs_used_s) | (mem_hit_rt_s & br_rt_used_s));
  assign br_stall_s   = br_ex_s | br_mem_s;
  assign stall        = load_use_s | link_use_s | br_stall_s;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] br_cnt_q, br_cnt_d;

  // Per-cycle hazard counters, wrapping naturally at 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    lu_cnt_d    = lu_cnt_q + {31'd0, load_use_s};
    br_cnt_d    = br_cnt_q + {31'd0, br_stall_s};
  end

  // Counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
      lu_cnt_q    <= 32'd0;
      br_cnt_q    <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_load_use     = lu_cnt_q;
  assign stat_branch_stall = br_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit: short instruction sequences
// with hand-derived forwarding codes and stall cycles.
module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_srca_rt, id_srcb_reg, id_mem_write;
  logic       id_is_branch, id_is_jr, id_reg_write, id_mem_read, id_link;
  logic [2:0] ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd, id_fwd_jr, id_fwd_br_a, id_fwd_br_b;
  logic       stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles, stat_load_use, stat_branch_stall;
`endif

  int checks = 0;
  int errors = 0;

  hazard_fwd_unit #(.REG_AW(5)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_srca_rt(id_srca_rt),
    .id_srcb_reg(id_srcb_reg), .id_mem_write(id_mem_write), .id_is_branch(id_is_branch),
    .id_is_jr(id_is_jr), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_link(id_link),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_fwd_c(ex_fwd_c), .mem_fwd(mem_fwd),
    .id_fwd_jr(id_fwd_jr), .id_fwd_br_a(id_fwd_br_a), .id_fwd_br_b(id_fwd_br_b),
    .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_load_use(stat_load_use),
    .stat_branch_stall(stat_branch_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic sart, input logic sbr,
                           input logic mw, input logic br, input logic jr,
                           input logic [4:0] dst, input logic rw, input logic mr, input logic lk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_srca_rt = sart; id_srcb_reg = sbr; id_mem_write = mw; id_is_branch = br;
    id_is_jr = jr; id_dst = dst; id_reg_write = rw; id_mem_read = mr; id_link = lk;
  endtask

  task automatic i_nop();
    set_instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic i_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_instr(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rd, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic i_addi(input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, rs, rt, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rt, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic i_lw(input logic [4:0] base, input logic [4:0] rt);
    set_instr(1'b1, base, rt, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rt, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic i_sw(input logic [4:0] base, input logic [4:0] rt);
    set_instr(1'b1, base, rt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic i_beq(input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic i_jal();
    set_instr(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1);
  endtask
  task automatic i_jr(input logic [4:0] rs);
    set_instr(1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    i_nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    i_beq(5'd3, 5'd4);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
    checks++; if ({ex_fwd_a, ex_fwd_b, ex_fwd_c} !== {FORWARD_IDEX, FORWARD_IDEX, FORWARD_IDEX}) begin
      errors++; $display("FAIL rst_ex_fwd: got %0d/%0d/%0d want 0/0/0", ex_fwd_a, ex_fwd_b, ex_fwd_c); end
    checks++; if (mem_fwd !== FORWARD_EXMEM) begin errors++; $display("FAIL rst_mem_fwd: got %0d want %0d", mem_fwd, FORWARD_EXMEM); end
    checks++; if ({id_fwd_jr, id_fwd_br_a, id_fwd_br_b} !== {FORWARD_RF, FORWARD_RF, FORWARD_RF}) begin
      errors++; $display("FAIL rst_id_fwd: got %0d/%0d/%0d want 0/0/0", id_fwd_jr, id_fwd_br_a, id_fwd_br_b); end
    i_nop();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_alu_alu();
    i_rtype(5'd1, 5'd2, 5'd3);            // add $3,$1,$2
    tick();
    i_rtype(5'd3, 5'd5, 5'd4);            // sub $4,$3,$5
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL aa_stall: got %0b want 0", stall); end
    tick();
    i_nop();
    #1;
    checks++; if (ex_fwd_a !== FORWARD_EXMEM) begin errors++; $display("FAIL aa_fwd_a: got %0d want %0d", ex_fwd_a, FORWARD_EXMEM); end
    checks++; if (ex_fwd_b !== FORWARD_IDEX) begin errors++; $display("FAIL aa_fwd_b: got %0d want %0d", ex_fwd_b, FORWARD_IDEX); end
    flush();
  endtask

  task automatic test_wb_priority();
    i_rtype(5'd1, 5'd2, 5'd3);            // add $3 (older)
    tick();
    i_rtype(5'd4, 5'd5, 5'd3);            // add $3 (younger)
    tick();
    i_rtype(5'd3, 5'd3, 5'd6);            // sub $6,$3,$3
    tick();
    i_nop();
    #1;
    checks++; if (ex_fwd_a !== FORWARD_EXMEM) begin errors++; $display("FAIL prio_a: got %0d want %0d", ex_fwd_a, FORWARD_EXMEM); end
    checks++; if (ex_fwd_b !== FORWARD_EXMEM) begin errors++; $display("FAIL prio_b: got %0d want %0d", ex_fwd_b, FORWARD_EXMEM); end
    flush();
    i_rtype(5'd1, 5'd2, 5'd7);            // add $7
    tick();
    i_nop();
    tick();
    i_rtype(5'd7, 5'd7, 5'd8);            // add $8,$7,$7
    tick();
    i_nop();
    #1;
    checks++; if (ex_fwd_a !== FORWARD_MEMWB) begin errors++; $display("FAIL wb_a: got %0d want %0d", ex_fwd_a, FORWARD_MEMWB); end
    checks++; if (ex_fwd_b !== FORWARD_MEMWB) begin errors++; $display("FAIL wb_b: got %0d want %0d", ex_fwd_b, FORWARD_MEMWB); end
    flush();
  endtask

  task automatic test_load_use();
    i_lw(5'd1, 5'd3);                     // lw $3,0($1)
    tick();
    i_rtype(5'd3, 5'd3, 5'd4);            // add $4,$3,$3
    id_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_invalid: got %0b want 0", stall); end
    id_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %0b want 1", stall); end
    tick();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %0b want 0", stall); end
    tick();
    i_nop();
    #1;
    checks++; if (ex_fwd_a !== FORWARD_MEMWB) begin errors++; $display("FAIL lu_fwd_a: got %0d want %0d", ex_fwd_a, FORWARD_MEMWB); end
    checks++; if (ex_fwd_b !== FORWARD_MEMWB) begin errors++; $display("FAIL lu_fwd_b: got %0d want %0d", ex_fwd_b, FORWARD_MEMWB); end
    flush();
  endtask

  task automatic test_load_store();
    i_lw(5'd1, 5'd3);                     // lw $3
    tick();
    i_sw(5'd2, 5'd3);                     // sw $3,4($2)
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ls_stall: got %0b want 0", stall); end
    tick();
    i_nop();
    #1;
    checks++; if (ex_fwd_c !== FORWARD_EXMEM) begin errors++; $display("FAIL ls_fwd_c: got %0d want %0d", ex_fwd_c, FORWARD_EXMEM); end
    checks++; if (mem_fwd !== FORWARD_EXMEM) begin errors++; $display("FAIL ls_mem_pre: got %0d want %0d", mem_fwd, FORWARD_EXMEM); end
    tick();
    #1;
    checks++; if (mem_fwd !== FORWARD_MEMWB) begin errors++; $display("FAIL ls_mem_fwd: got %0d want %0d", mem_fwd, FORWARD_MEMWB); end
    flush();
  endtask

  task automatic test_branch();
    i_lw(5'd1, 5'd3);                     // lw $3
    tick();
    i_beq(5'd3, 5'd0);                    // beq $3,$0
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall1: got %0b want 1", stall); end
    tick();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall2: got %0b want 1", stall); end
    tick();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall3: got %0b want 0", stall); end
    checks++; if (id_fwd_br_a !== FORWARD_RF) begin errors++; $display("FAIL lb_fwd: got %0d want %0d", id_fwd_br_a, FORWARD_RF); end
    flush();
    i_rtype(5'd1, 5'd2, 5'd5);            // add $5
    tick();
    i_beq(5'd6, 5'd5);                    // beq $6,$5
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ab_stall1: got %0b want 1", stall); end
    tick();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ab_stall2: got %0b want 0", stall); end
    checks++; if (id_fwd_br_b !== FORWARD_EXMEM_ALURESULT) begin errors++; $display("FAIL ab_fwd_b: got %0d want %0d", id_fwd_br_b, FORWARD_EXMEM_ALURESULT); end
    checks++; if (id_fwd_br_a !== FORWARD_RF) begin errors++; $display("FAIL ab_fwd_a: got %0d want %0d", id_fwd_br_a, FORWARD_RF); end
    flush();
  endtask

  task automatic test_jal_jr();
    i_jal();
    tick();
    i_nop();
    tick();
    i_jr(5'd31);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_stall: got %0b want 0", stall); end
    checks++; if (id_fwd_jr !== FORWARD_EXMEM_PCPLUS4) begin errors++; $display("FAIL jr_fwd: got %0d want %0d", id_fwd_jr, FORWARD_EXMEM_PCPLUS4); end
    flush();
    i_jal();
    tick();
    i_jr(5'd31);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jr_b2b_stall: got %0b want 1", stall); end
    flush();
  endtask

  task automatic test_zero_reg();
    i_addi(5'd1, 5'd0);                   // addi $0,$1,5
    tick();
    i_rtype(5'd0, 5'd0, 5'd2);            // add $2,$0,$0
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL z_stall: got %0b want 0", stall); end
    tick();
    i_nop();
    #1;
    checks++; if ({ex_fwd_a, ex_fwd_b, ex_fwd_c} !== {FORWARD_IDEX, FORWARD_IDEX, FORWARD_IDEX}) begin
      errors++; $display("FAIL z_fwd: got %0d/%0d/%0d want 0/0/0", ex_fwd_a, ex_fwd_b, ex_fwd_c); end
    flush();
  endtask

  task automatic test_reset_mid_stall();
    i_lw(5'd1, 5'd3);
    tick();
    i_rtype(5'd3, 5'd3, 5'd4);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rs_pre: got %0b want 1", stall); end
    rstn = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs_drop: got %0b want 0", stall); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs_after: got %0b want 0", stall); end
    tick();
    i_nop();
    #1;
    checks++; if (ex_fwd_a !== FORWARD_IDEX) begin errors++; $display("FAIL rs_empty: got %0d want %0d", ex_fwd_a, FORWARD_IDEX); end
    flush();
  endtask

  initial begin
    rstn = 1'b0;
    i_nop();
    #2;
    test_reset();
    test_alu_alu();
    test_wb_priority();
    test_load_use();
    test_load_store();
    test_branch();
    test_jal_jr();
    test_zero_reg();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
